// File: rtl/memory_stage.sv
// EX/MEM to MEM/WB pipeline stage. Non-memory beats pass through in one cycle; data-memory
// accesses stall the pipeline until MemAck arrives or a bounded wait expires.
module memory_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [75:0] In,
  input  logic        InValid,
  output logic        Stall,
  output logic [19:0] MemAddr,
  output logic [15:0] MemWData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [15:0] MemRData,
  input  logic        MemAck,
  output logic [37:0] Out,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [15:0] r_alu;
  logic [2:0]  r_rdst;
  logic        r_wb;
  logic        r_ldd;
  logic        r_is_read;
  logic [19:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [37:0] r_out;
  logic        r_timeout;

  logic [31:0] w_sp;
  logic [15:0] w_rsrc;
  logic [15:0] w_alu;
  logic [2:0]  w_rdst;
  logic [1:0]  w_mem_op;
  logic [1:0]  w_sp_op;
  logic        w_wb;
  logic        w_ldd;
  logic        w_is_read;
  logic        w_is_write;
  logic        w_access;
  logic [19:0] w_addr;
  logic [3:0]  w_wait_inc;
  logic        w_expire;
  logic        w_unused;

  assign w_sp       = In[75:44];
  assign w_rsrc     = In[43:28];
  assign w_alu      = In[27:12];
  assign w_rdst     = In[8:6];
  assign w_mem_op   = In[5:4];
  assign w_sp_op    = In[3:2];
  assign w_wb       = In[1];
  assign w_ldd      = In[0];
  // Mem op 11 is deliberately decoded as no access, identical to 00.
  assign w_is_read  = (w_mem_op == 2'b01);
  assign w_is_write = (w_mem_op == 2'b10);
  assign w_access   = w_is_read | w_is_write;
  assign w_addr     = (w_sp_op != 2'b00) ? w_sp[19:0] : {4'b0000, w_alu};
  assign w_wait_inc = r_wait_cnt + 4'd1;
  // Upper SP bits and the Rsrc address have no role in this stage.
  assign w_unused   = ^{In[75:64], In[11:9]};

  assign Stall    = (r_state != IDLE);
  assign MemAddr  = r_mem_addr;
  assign MemWData = r_mem_wdata;
  assign MemRead  = r_mem_read;
  assign MemWrite = r_mem_write;
  assign Out      = r_out;
  assign Timeout  = r_timeout;

  always_comb begin
    w_next_state = r_state;
    w_expire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (InValid && w_access) begin
          w_next_state = WAIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        // An ack in the cycle the limit is reached still wins over the timeout.
        if (MemAck) begin
          w_next_state = DONE;
        end else if (w_wait_inc == LP_TIMEOUT) begin
          w_expire     = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = WAIT;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wait_cnt  <= 4'd0;
      r_alu       <= 16'h0000;
      r_rdst      <= 3'd0;
      r_wb        <= 1'b0;
      r_ldd       <= 1'b0;
      r_is_read   <= 1'b0;
      r_mem_addr  <= 20'h00000;
      r_mem_wdata <= 16'h0000;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_out       <= 38'd0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid && w_access) begin
            r_alu       <= w_alu;
            r_rdst      <= w_rdst;
            r_wb        <= w_wb;
            r_ldd       <= w_ldd;
            r_is_read   <= w_is_read;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_rsrc;
            r_mem_read  <= w_is_read;
            r_mem_write <= w_is_write;
            r_wait_cnt  <= 4'd0;
            r_out[0]    <= 1'b0;
          end else if (InValid) begin
            r_out <= {16'h0000, w_alu, w_rdst, w_wb, w_ldd, 1'b1};
          end else begin
            r_out[0] <= 1'b0;
          end
        end
        WAIT: begin
          if (MemAck) begin
            r_out       <= {(r_is_read ? MemRData : 16'h0000), r_alu, r_rdst, r_wb, r_ldd, 1'b1};
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end else if (w_expire) begin
            r_out       <= {16'h0000, r_alu, r_rdst, r_wb, r_ldd, 1'b1};
            r_timeout   <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wait_cnt  <= w_wait_inc;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        DONE:    r_out[0] <= 1'b0;
        default: r_out[0] <= 1'b0;
      endcase
    end
  end

endmodule
